// File: rtl/tmds_word_aligner_if.sv
// Bus bundle for one TMDS word aligner channel: raw deserialized word in,
// aligned word plus token/lock status out.
interface tmds_word_aligner_if;
  logic [9:0] i_data;
  logic [9:0] o_data;
  logic       o_ctrl;
  logic [1:0] o_ctrl_code;
  logic       o_locked;
  logic [3:0] o_offset;

  modport master (
    output i_data,
    input  o_data,
    input  o_ctrl,
    input  o_ctrl_code,
    input  o_locked,
    input  o_offset
  );

  modport slave (
    input  i_data,
    output o_data,
    output o_ctrl,
    output o_ctrl_code,
    output o_locked,
    output o_offset
  );
endinterface

// File: rtl/tmds_word_aligner.sv
// TMDS word aligner: slides a 10-bit window over two consecutive deserialized words, hunts for
// the bit offset at which control tokens appear, and emits aligned words once locked.
module tmds_word_aligner #(
  parameter int unsigned SEARCH_WINDOW = 2048,
  parameter int unsigned TOKEN_COUNT   = 8,
  parameter int unsigned LOSS_WINDOW   = 4096
) (
  input logic               i_clk,
  input logic               i_rst_n,
  tmds_word_aligner_if.slave bus
);

  localparam int unsigned WinW  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int unsigned RunW  = (TOKEN_COUNT > 1) ? $clog2(TOKEN_COUNT) : 1;
  localparam int unsigned LossW = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;

  localparam logic [WinW-1:0]  WinLast  = WinW'(SEARCH_WINDOW - 1);
  localparam logic [RunW-1:0]  RunLast  = RunW'(TOKEN_COUNT - 1);
  localparam logic [LossW-1:0] LossLast = LossW'(LOSS_WINDOW - 1);

  typedef enum logic [1:0] {StSearch, StConfirm, StLocked} state_e;

  state_e            r_state, w_state_nxt;
  logic [9:0]        r_word;
  logic [3:0]        r_offset, w_offset_nxt;
  logic [WinW-1:0]   r_win_cnt, w_win_cnt_nxt;
  logic [RunW-1:0]   r_run_cnt, w_run_cnt_nxt;
  logic [LossW-1:0]  r_loss_cnt, w_loss_cnt_nxt;
  logic [9:0]        r_data;
  logic              r_ctrl;
  logic [1:0]        r_ctrl_code;

  logic [19:0]       w_window;
  logic [9:0]        w_slice;
  logic              w_match;
  logic [1:0]        w_code;
  logic [3:0]        w_offset_adv;

  // Older word in the low half so bit k of the window is the k-th serial bit.
  assign w_window     = {bus.i_data, r_word};
  assign w_slice      = 10'(w_window >> r_offset);
  assign w_offset_adv = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

  // Decode the four TMDS control tokens on the current slice.
  always_comb begin
    w_match = 1'b1;
    w_code  = 2'b00;
    case (w_slice)
      10'b1101010100: w_code = 2'b00;
      10'b0010101011: w_code = 2'b01;
      10'b0101010100: w_code = 2'b10;
      10'b1010101011: w_code = 2'b11;
      default:        w_match = 1'b0;
    endcase
  end

  // Alignment FSM next state; counters are cleared on every state change.
  always_comb begin
    w_state_nxt    = r_state;
    w_offset_nxt   = r_offset;
    w_win_cnt_nxt  = r_win_cnt;
    w_run_cnt_nxt  = r_run_cnt;
    w_loss_cnt_nxt = r_loss_cnt;
    case (r_state)
      StSearch: begin
        if (w_match) begin
          w_state_nxt   = StConfirm;
          w_win_cnt_nxt = '0;
          w_run_cnt_nxt = RunW'(1);
        end else if (r_win_cnt == WinLast) begin
          w_offset_nxt  = w_offset_adv;
          w_win_cnt_nxt = '0;
        end else begin
          w_win_cnt_nxt = r_win_cnt + 1'b1;
        end
      end
      StConfirm: begin
        if (w_match) begin
          if (r_run_cnt == RunLast) begin
            w_state_nxt    = StLocked;
            w_run_cnt_nxt  = '0;
            w_loss_cnt_nxt = '0;
          end else begin
            w_run_cnt_nxt = r_run_cnt + 1'b1;
          end
        end else begin
          // Abandon this offset so a lone false match cannot trap the search.
          w_state_nxt   = StSearch;
          w_offset_nxt  = w_offset_adv;
          w_run_cnt_nxt = '0;
          w_win_cnt_nxt = '0;
        end
      end
      StLocked: begin
        if (w_match) begin
          w_loss_cnt_nxt = '0;
        end else if (r_loss_cnt == LossLast) begin
          // Offset is kept so the search restarts from the last good position.
          w_state_nxt    = StSearch;
          w_loss_cnt_nxt = '0;
          w_win_cnt_nxt  = '0;
        end else begin
          w_loss_cnt_nxt = r_loss_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt    = StSearch;
        w_win_cnt_nxt  = '0;
        w_run_cnt_nxt  = '0;
        w_loss_cnt_nxt = '0;
      end
    endcase
  end

  // State, counters, word history and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StSearch;
      r_word      <= '0;
      r_offset    <= '0;
      r_win_cnt   <= '0;
      r_run_cnt   <= '0;
      r_loss_cnt  <= '0;
      r_data      <= '0;
      r_ctrl      <= 1'b0;
      r_ctrl_code <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_word      <= bus.i_data;
      r_offset    <= w_offset_nxt;
      r_win_cnt   <= w_win_cnt_nxt;
      r_run_cnt   <= w_run_cnt_nxt;
      r_loss_cnt  <= w_loss_cnt_nxt;
      r_data      <= w_slice;
      r_ctrl      <= w_match;
      r_ctrl_code <= w_code;
    end
  end

  assign bus.o_data      = r_data;
  assign bus.o_ctrl      = r_ctrl;
  assign bus.o_ctrl_code = r_ctrl_code;
  assign bus.o_locked    = (r_state == StLocked);
  assign bus.o_offset    = r_offset;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner with SEARCH_WINDOW=16, TOKEN_COUNT=4, LOSS_WINDOW=32.
// Edge E1 is the first rising edge after reset release; expected values are indexed by edge.
module tb_tmds_word_aligner;

  localparam logic [9:0] Tok0 = 10'b1101010100;
  localparam logic [9:0] Tok1 = 10'b0010101011;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;
  int   tok_seen;

  tmds_word_aligner_if bus_if ();

  tmds_word_aligner #(
    .SEARCH_WINDOW(16),
    .TOKEN_COUNT  (4),
    .LOSS_WINDOW  (32)
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int exp_off, input logic exp_lock);
    check_eq({tag, "_off"}, 32'(bus_if.o_offset), 32'(exp_off));
    check_eq({tag, "_lock"}, 32'(bus_if.o_locked), 32'(exp_lock));
  endtask

  task automatic chk_token(input string tag, input logic [9:0] exp_data, input logic [1:0] exp_code);
    check_eq({tag, "_data"}, 32'(bus_if.o_data), 32'(exp_data));
    check_eq({tag, "_ctrl"}, 32'(bus_if.o_ctrl), 32'd1);
    check_eq({tag, "_code"}, 32'(bus_if.o_ctrl_code), 32'(exp_code));
  endtask

  task automatic chk_zero(input string tag);
    check_eq({tag, "_data"}, 32'(bus_if.o_data), 32'd0);
    check_eq({tag, "_ctrl"}, 32'(bus_if.o_ctrl), 32'd0);
    check_eq({tag, "_code"}, 32'(bus_if.o_ctrl_code), 32'd0);
    check_eq({tag, "_lock"}, 32'(bus_if.o_locked), 32'd0);
    check_eq({tag, "_off"}, 32'(bus_if.o_offset), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across one edge with d already on the input, then releases at a falling edge.
  task automatic do_reset(input logic [9:0] d, input string tag);
    @(negedge clk);
    rst_n        = 1'b0;
    bus_if.i_data = d;
    tick();
    chk_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Serial stream of repeated token t, delayed by k bits relative to word boundaries.
  function automatic logic [9:0] rotl10(input logic [9:0] v, input int k);
    logic [19:0] dbl;
    dbl = {v, v} << k;
    return dbl[19:10];
  endfunction

  initial begin
    bus_if.i_data = '0;

    // Aligned Tok0 stream: lock on the edge that outputs the 4th token (E5).
    do_reset(Tok0, "t1_rst");
    tok_seen = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (bus_if.o_ctrl) tok_seen++;
      chk_state("t1", 0, n >= 5);
      if (n == 1) check_eq("t1_first_data", 32'(bus_if.o_data), 32'd0);
      if (n == 5) begin
        check_eq("t1_tok_at_lock", 32'(tok_seen), 32'd4);
        chk_token("t1_lock", Tok0, 2'b00);
      end
    end

    // Tok1 stream shifted by 3: offset steps at E16/E32/E48, lock at E52.
    do_reset(rotl10(Tok1, 3), "t2_rst");
    for (int n = 1; n <= 56; n++) begin
      tick();
      chk_state("t2", (n < 48) ? n / 16 : 3, n >= 52);
      if (n == 52) chk_token("t2_lock", Tok1, 2'b01);
    end

    // Single token then non-token: CONFIRM at E2, abort to offset 1 at E3.
    do_reset(Tok0, "t3_rst");
    tick();
    bus_if.i_data = 10'h1E3;
    tick();
    chk_state("t3_e2", 0, 1'b0);
    check_eq("t3_e2_ctrl", 32'(bus_if.o_ctrl), 32'd1);
    tick();
    chk_state("t3_e3", 1, 1'b0);
    tick();
    chk_state("t3_e4", 1, 1'b0);

    // Loss window: 31 gaps keep lock, token resets, 32nd gap word drops lock at E69.
    do_reset(Tok0, "t4_rst");
    for (int n = 1; n <= 72; n++) begin
      tick();
      chk_state("t4", 0, (n >= 5) && (n <= 68));
      bus_if.i_data = ((n + 1 <= 4) || (n + 1 == 36)) ? Tok0 : 10'h000;
    end

    // No tokens: offset walks 0..9 and wraps, advancing every 16 edges.
    do_reset(10'h000, "t5_rst");
    for (int n = 1; n <= 161; n++) begin
      tick();
      chk_state("t5", (n / 16) % 10, 1'b0);
    end

    // Lock at offset 5 (E84), asynchronous reset mid-cycle, then identical relock.
    do_reset(rotl10(Tok0, 5), "t6_rst");
    for (int n = 1; n <= 90; n++) begin
      tick();
      chk_state("t6a", (n < 80) ? n / 16 : 5, n >= 84);
      if (n == 84) chk_token("t6a_lock", Tok0, 2'b00);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async");
    tick();
    chk_zero("t6_hold");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 90; n++) begin
      tick();
      chk_state("t6b", (n < 80) ? n / 16 : 5, n >= 84);
      if (n == 84) chk_token("t6b_lock", Tok0, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
